// File: rtl/pool_ui_pkg.sv
// Shared types and widths for the pool game UI objects.
//   banner_state_t : score banner sequencer states
//   coord_t        : pixel coordinate pair (x, y)
package pool_ui_pkg;

  localparam int unsigned COORD_W = 11;
  localparam int unsigned SCORE_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SLIDE = 3'd1,
    TALLY = 3'd2,
    BLINK = 3'd3,
    HOLD  = 3'd4,
    DONE  = 3'd5
  } banner_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_t;

endpackage

// File: rtl/sprite_bracket.sv
// Registered rectangle hit test for a W x H sprite anchored at top_left_i.
// Ports:
//   clk, resetN    clock and async active-low reset
//   pixel_i        current pixel coordinate
//   top_left_i     sprite top-left coordinate
//   enable_i       sprite visible
//   inside_o       pixel inside visible sprite (1-cycle latency)
//   offset_x_o/y_o pixel minus top-left when inside, else 0
module sprite_bracket
  import pool_ui_pkg::*;
#(
  parameter int unsigned W = 80,
  parameter int unsigned H = 20
) (
  input  logic               clk,
  input  logic               resetN,
  input  coord_t             pixel_i,
  input  coord_t             top_left_i,
  input  logic               enable_i,
  output logic               inside_o,
  output logic [COORD_W-1:0] offset_x_o,
  output logic [COORD_W-1:0] offset_y_o
);

  // One extra bit so the right/bottom edge cannot wrap near the screen limit.
  localparam int unsigned EXT_W = COORD_W + 1;

  logic [EXT_W-1:0]   x_end_c;
  logic [EXT_W-1:0]   y_end_c;
  logic               hit_c;
  logic               inside_q;
  logic [COORD_W-1:0] offset_x_q;
  logic [COORD_W-1:0] offset_y_q;

  assign x_end_c = EXT_W'(top_left_i.x) + EXT_W'(W);
  assign y_end_c = EXT_W'(top_left_i.y) + EXT_W'(H);
  assign hit_c   = enable_i
                && (pixel_i.x >= top_left_i.x) && (EXT_W'(pixel_i.x) < x_end_c)
                && (pixel_i.y >= top_left_i.y) && (EXT_W'(pixel_i.y) < y_end_c);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      inside_q   <= 1'b0;
      offset_x_q <= '0;
      offset_y_q <= '0;
    end else begin
      inside_q   <= hit_c;
      offset_x_q <= hit_c ? COORD_W'(pixel_i.x - top_left_i.x) : '0;
      offset_y_q <= hit_c ? COORD_W'(pixel_i.y - top_left_i.y) : '0;
    end
  end

  assign inside_o   = inside_q;
  assign offset_x_o = offset_x_q;
  assign offset_y_o = offset_y_q;

endmodule

// File: rtl/score_banner_ctrl.sv
// End-of-game score banner sequencer: slide down, tally score, blink, hold.
// Ports:
//   clk, resetN           pixel clock, async active-low reset
//   startOfFrame          one-cycle frame pulse; animation advances on it
//   pixelX, pixelY        current pixel
//   show_req, score_in    start request and final score (latched together)
//   ack                   player dismiss, honoured only in HOLD
//   InsideRectangle       pixel inside visible banner (registered)
//   offsetX, offsetY      bitmap offsets when inside, else 0
//   shown_score           score value currently displayed
//   busy                  high outside IDLE
//   done                  one-cycle pulse at end of sequence
module score_banner_ctrl
  import pool_ui_pkg::*;
#(
  parameter int unsigned OBJECT_WIDTH_X  = 80,
  parameter int unsigned OBJECT_HEIGHT_Y = 20,
  parameter int unsigned POS_X           = 280,
  parameter int unsigned START_Y         = 0,
  parameter int unsigned FINAL_Y         = 230,
  parameter int unsigned SLIDE_STEP      = 4,
  parameter int unsigned BLINK_FRAMES    = 15,
  parameter int unsigned BLINK_COUNT     = 3,
  parameter int unsigned HOLD_FRAMES     = 180
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic [COORD_W-1:0] pixelX,
  input  logic [COORD_W-1:0] pixelY,
  input  logic               show_req,
  input  logic [SCORE_W-1:0] score_in,
  input  logic               ack,
  output logic               InsideRectangle,
  output logic [COORD_W-1:0] offsetX,
  output logic [COORD_W-1:0] offsetY,
  output logic [SCORE_W-1:0] shown_score,
  output logic               busy,
  output logic               done
);

  localparam int unsigned EXT_W     = COORD_W + 1;
  localparam int unsigned FRAME_MAX = (HOLD_FRAMES > BLINK_FRAMES) ? HOLD_FRAMES : BLINK_FRAMES;
  localparam int unsigned FRAME_W   = $clog2(FRAME_MAX + 1);
  localparam int unsigned TOGGLES   = 2 * BLINK_COUNT;
  localparam int unsigned BLINK_W   = $clog2(TOGGLES + 1);

  banner_state_t      state_q, state_d;
  logic [COORD_W-1:0] cur_y_q, cur_y_d;
  logic               visible_q, visible_d;
  logic [SCORE_W-1:0] target_q, target_d;
  logic [SCORE_W-1:0] shown_q, shown_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [BLINK_W-1:0] blink_q, blink_d;
  logic               busy_q, done_q;
  logic [EXT_W-1:0]   y_step_c;

  assign y_step_c = EXT_W'(cur_y_q) + EXT_W'(SLIDE_STEP);

  // Next-state and datapath updates
  always_comb begin
    state_d   = state_q;
    cur_y_d   = cur_y_q;
    visible_d = visible_q;
    target_d  = target_q;
    shown_d   = shown_q;
    frame_d   = frame_q;
    blink_d   = blink_q;
    case (state_q)
      IDLE: begin
        visible_d = 1'b0;
        if (show_req) begin
          target_d  = score_in;
          cur_y_d   = COORD_W'(START_Y);
          shown_d   = '0;
          state_d   = SLIDE;
          visible_d = 1'b1;
          frame_d   = '0;
        end
      end
      SLIDE: begin
        if (startOfFrame) begin
          if (y_step_c >= EXT_W'(FINAL_Y)) begin
            cur_y_d = COORD_W'(FINAL_Y);
            state_d = TALLY;
            frame_d = '0;
          end else begin
            cur_y_d = COORD_W'(y_step_c);
          end
        end
      end
      TALLY: begin
        if (startOfFrame) begin
          if (shown_q == target_q) begin
            state_d   = BLINK;
            visible_d = 1'b0;
            frame_d   = '0;
            blink_d   = '0;
          end else begin
            shown_d = shown_q + SCORE_W'(1);
          end
        end
      end
      BLINK: begin
        if (startOfFrame) begin
          if (frame_q == FRAME_W'(BLINK_FRAMES - 1)) begin
            frame_d   = '0;
            visible_d = ~visible_q;
            // Last toggle of the final pair always lands on visible.
            if (blink_q == BLINK_W'(TOGGLES - 1)) begin
              state_d   = HOLD;
              visible_d = 1'b1;
              blink_d   = '0;
            end else begin
              blink_d = blink_q + BLINK_W'(1);
            end
          end else begin
            frame_d = frame_q + FRAME_W'(1);
          end
        end
      end
      HOLD: begin
        // ack and expiry share one transition, so a coincident pair yields one DONE.
        if (ack || (startOfFrame && frame_q == FRAME_W'(HOLD_FRAMES - 1))) begin
          state_d   = DONE;
          visible_d = 1'b0;
          frame_d   = '0;
        end else if (startOfFrame) begin
          frame_d = frame_q + FRAME_W'(1);
        end
      end
      DONE: begin
        visible_d = 1'b0;
        state_d   = IDLE;
        frame_d   = '0;
      end
      default: begin
        state_d   = IDLE;
        visible_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      cur_y_q   <= COORD_W'(START_Y);
      visible_q <= 1'b0;
      target_q  <= '0;
      shown_q   <= '0;
      frame_q   <= '0;
      blink_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_y_q   <= cur_y_d;
      visible_q <= visible_d;
      target_q  <= target_d;
      shown_q   <= shown_d;
      frame_q   <= frame_d;
      blink_q   <= blink_d;
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
    end
  end

  coord_t pixel_c, top_left_c;
  assign pixel_c    = '{x: pixelX, y: pixelY};
  assign top_left_c = '{x: COORD_W'(POS_X), y: cur_y_q};

  sprite_bracket #(
    .W (OBJECT_WIDTH_X),
    .H (OBJECT_HEIGHT_Y)
  ) u_bracket (
    .clk        (clk),
    .resetN     (resetN),
    .pixel_i    (pixel_c),
    .top_left_i (top_left_c),
    .enable_i   (visible_q),
    .inside_o   (InsideRectangle),
    .offset_x_o (offsetX),
    .offset_y_o (offsetY)
  );

  assign shown_score = shown_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_score_banner_ctrl.sv
// Directed bench for score_banner_ctrl: full sequences, pixel table, ack/expiry, reset abort.
module tb_score_banner_ctrl;
  import pool_ui_pkg::*;

  logic               clk = 1'b0;
  logic               resetN;
  logic               startOfFrame;
  logic [COORD_W-1:0] pixelX, pixelY;
  logic               show_req;
  logic [SCORE_W-1:0] score_in;
  logic               ack;
  logic               InsideRectangle;
  logic [COORD_W-1:0] offsetX, offsetY;
  logic [SCORE_W-1:0] shown_score;
  logic               busy, done;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  typedef struct {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               in;
    logic [COORD_W-1:0] ox;
    logic [COORD_W-1:0] oy;
  } pix_vec_t;

  pix_vec_t vecs[6];

  score_banner_ctrl dut (
    .clk             (clk),
    .resetN          (resetN),
    .startOfFrame    (startOfFrame),
    .pixelX          (pixelX),
    .pixelY          (pixelY),
    .show_req        (show_req),
    .score_in        (score_in),
    .ack             (ack),
    .InsideRectangle (InsideRectangle),
    .offsetX         (offsetX),
    .offsetY         (offsetY),
    .shown_score     (shown_score),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // One frame = sof pulse cycle + one idle cycle, so registered pixel outputs settle.
  task automatic sofs(input int n);
    repeat (n) begin
      startOfFrame = 1'b1;
      step();
      startOfFrame = 1'b0;
      step();
    end
  endtask

  task automatic start(input logic [SCORE_W-1:0] s);
    show_req = 1'b1;
    score_in = s;
    step();
    show_req = 1'b0;
    score_in = 8'hAA;
  endtask

  task automatic pix(input int x, input int y);
    pixelX = COORD_W'(x);
    pixelY = COORD_W'(y);
    step();
  endtask

  initial begin
    vecs[0] = '{x: 11'd280, y: 11'd230, in: 1'b1, ox: 11'd0,  oy: 11'd0};
    vecs[1] = '{x: 11'd359, y: 11'd249, in: 1'b1, ox: 11'd79, oy: 11'd19};
    vecs[2] = '{x: 11'd360, y: 11'd249, in: 1'b0, ox: 11'd0,  oy: 11'd0};
    vecs[3] = '{x: 11'd280, y: 11'd250, in: 1'b0, ox: 11'd0,  oy: 11'd0};
    vecs[4] = '{x: 11'd279, y: 11'd240, in: 1'b0, ox: 11'd0,  oy: 11'd0};
    vecs[5] = '{x: 11'd300, y: 11'd229, in: 1'b0, ox: 11'd0,  oy: 11'd0};

    resetN = 1'b0; startOfFrame = 1'b0; show_req = 1'b0; ack = 1'b0;
    score_in = '0; pixelX = 11'd290; pixelY = 11'd235;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_inside", InsideRectangle, 0);
    chk("rst_shown", shown_score, 0);
    chk("rst_offx", offsetX, 0);
    resetN = 1'b1;
    step();

    // Run A: score 5, ignored re-request and early ack, dismissed by ack at hold frame 10
    start(8'd5);
    chk("a_busy", busy, 1);
    chk("a_shown0", shown_score, 0);
    sofs(10);
    show_req = 1'b1; score_in = 8'd9; ack = 1'b1;
    step();
    show_req = 1'b0; ack = 1'b0;
    sofs(47);
    pix(285, 228);
    chk("a_y57_in", InsideRectangle, 1);
    chk("a_y57_ox", offsetX, 5);
    chk("a_y57_oy", offsetY, 0);
    chk("a_y57_shown", shown_score, 0);
    sofs(1);
    pix(280, 230);
    chk("a_y58_in", InsideRectangle, 1);
    chk("a_y58_oy", offsetY, 0);
    chk("a_slide_len", shown_score, 0);
    for (int k = 1; k <= 5; k++) begin
      sofs(1);
      chk($sformatf("a_tally%0d", k), shown_score, k);
    end
    pixelX = 11'd290; pixelY = 11'd235;
    sofs(1);
    chk("a_target_kept", shown_score, 5);
    chk("a_blink_start", InsideRectangle, 0);
    for (int j = 1; j <= 90; j++) begin
      logic e;
      e = (j < 90) ? ((j / 15) % 2 == 1) : 1'b1;
      sofs(1);
      chk($sformatf("a_blink%0d", j), InsideRectangle, e);
      if (j % 30 == 0) chk($sformatf("a_blink_busy%0d", j), busy, 1);
    end
    for (int i = 0; i < 6; i++) begin
      pix(vecs[i].x, vecs[i].y);
      chk($sformatf("pix%0d_in", i), InsideRectangle, vecs[i].in);
      chk($sformatf("pix%0d_ox", i), offsetX, vecs[i].ox);
      chk($sformatf("pix%0d_oy", i), offsetY, vecs[i].oy);
    end
    sofs(10);
    chk("a_hold_busy", busy, 1);
    chk("a_no_early_done", done_cnt, 0);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("a_done_hi", done, 1);
    step();
    chk("a_done_lo", done, 0);
    chk("a_idle_busy", busy, 0);
    chk("a_done_cnt", done_cnt, 1);
    chk("a_idle_shown", shown_score, 5);
    step();

    // Run B: score 0 exits tally on the first frame; auto-dismiss after 180 hold frames
    pixelX = 11'd290; pixelY = 11'd235;
    start(8'd0);
    chk("b_shown_clr", shown_score, 0);
    sofs(58);
    chk("b_tally_vis", InsideRectangle, 1);
    sofs(1);
    chk("b_zero_exit", InsideRectangle, 0);
    sofs(90);
    chk("b_hold_vis", InsideRectangle, 1);
    sofs(179);
    chk("b_hold179_busy", busy, 1);
    chk("b_hold179_cnt", done_cnt, 1);
    sofs(1);
    chk("b_expire_cnt", done_cnt, 2);
    chk("b_expire_busy", busy, 0);

    // Run C: ack coincident with hold expiry gives a single done pulse
    start(8'd3);
    sofs(58 + 4 + 90 + 179);
    chk("c_pre_busy", busy, 1);
    startOfFrame = 1'b1; ack = 1'b1;
    step();
    startOfFrame = 1'b0; ack = 1'b0;
    chk("c_done_hi", done, 1);
    step();
    chk("c_done_lo", done, 0);
    step(); step();
    chk("c_done_cnt", done_cnt, 3);
    chk("c_busy", busy, 0);

    // Run D: reset mid-tally aborts without done
    start(8'd5);
    sofs(60);
    chk("d_shown2", shown_score, 2);
    resetN = 1'b0;
    #2;
    chk("d_rst_busy", busy, 0);
    chk("d_rst_inside", InsideRectangle, 0);
    chk("d_rst_shown", shown_score, 0);
    chk("d_rst_done", done, 0);
    step(); step();
    resetN = 1'b1;
    step(); step();
    chk("d_done_cnt", done_cnt, 3);
    chk("d_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
